flag_unit: RTL
==============

FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 The module SHALL provide parameter RESET_FLAGS, default 4'b0000, as the {N,Z,C,V} value loaded on reset.
REQ-002 The module SHALL provide parameter Delay, default 50, as the gate delay in ps applied to the registered outputs.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-low.
REQ-005 setFlags  input  1  when high, capture the ALU flags this cycle.
REQ-006 aluFlags  input  4  {N,Z,C,V} from the ALU; Z is the zero-check result.
REQ-007 condValid  input  1  a branch condition request is present.
REQ-008 cond  input  4  ARM condition code to evaluate.
REQ-009 condReady  output  1  the request is accepted this cycle when condValid is also high.
REQ-010 takenValid  output  1  a branch decision is held on taken.
REQ-011 taken  output  1  branch decision.
REQ-012 takenReady  input  1  the consumer takes the decision this cycle.
REQ-013 flags  output  4  current architectural {N,Z,C,V} register.

Function
REQ-014 The flags register SHALL load aluFlags on a clock edge with setFlags=1, and SHALL hold its value otherwise.
REQ-015 Conditions SHALL evaluate as follows:
- 0 EQ: Z; 1 NE: !Z
- 2 HS: C; 3 LO: !C
- 4 MI: N; 5 PL: !N
- 6 VS: V; 7 VC: !V
- 8 HI: C&!Z; 9 LS: !C|Z
- 10 GE: N==V; 11 LT: N!=V
- 12 GT: !Z&(N==V); 13 LE: Z|(N!=V)
- 14 AL and 15 NV: always 1
REQ-016 The result stage SHALL be a one-entry buffer with two states:
- EMPTY: takenValid=0
- FULL: takenValid=1
REQ-017 In EMPTY, condReady SHALL be 1 (subject to REQ-021). In FULL, condReady SHALL equal takenReady.
REQ-018 An accepted request (condValid&condReady) SHALL produce takenValid=1 starting the next cycle, with taken registered from the evaluation.
- Latency is one cycle.
- FULL stays FULL when a new request is accepted in the same cycle the consumer takes the old decision.
REQ-019 FULL SHALL return to EMPTY on takenReady=1 with no new accept.
- taken SHALL hold its value while takenValid=1 and takenReady=0.
REQ-020 Evaluation SHALL use the flags register value unless REQ-021 applies.
REQ-021 When setFlags and condValid are high in the same cycle, behaviour SHALL follow the FLAG_BYPASS_EN setting (Configuration).
REQ-022 condValid held with condReady=0 SHALL NOT be lost; the request is accepted on a later cycle.

Reset
REQ-023 Reset low SHALL immediately force the following, regardless of clk:
- flags = RESET_FLAGS
- state = EMPTY, takenValid = 0
- taken = 0, condReady = 0
REQ-024 Reset asserted mid-transaction SHALL discard any pending decision.
REQ-025 After reset deasserts, condReady SHALL be 1 from the first following clock edge.

Configuration
REQ-026 Macro FLAG_BYPASS_EN SHALL control same-cycle flag hazards.
- Defined: the evaluation uses aluFlags directly, so a same-cycle request is accepted without stall.
- Undefined: condReady SHALL be forced to 0 for that cycle, and the request is accepted the next cycle using the updated register.

Verification
REQ-027 Reset low with clk stopped -> flags=0000, takenValid=0, taken=0 with no clock edge.
REQ-028 setFlags=1, aluFlags=0100; then cond=0 (EQ) accepted -> next cycle takenValid=1, taken=1; cond=1 (NE) -> taken=0.
REQ-029 flags=1001 (N=1, V=1); cond=10 (GE) -> taken=1; cond=12 (GT) -> taken=1; flags=1000, cond=11 (LT) -> taken=1.
REQ-030 FULL with takenReady=0 for 3 cycles and condValid=1 -> condReady=0 and taken stable; takenReady=1 -> new request accepted that cycle and takenValid stays 1.
REQ-031 flags=0000; same cycle setFlags=1, aluFlags=0100, cond=0 -> with FLAG_BYPASS_EN: accepted, taken=1 next cycle; without it: condReady=0 for one cycle, then accepted and taken=1 one cycle after that.
REQ-032 Reset asserted while FULL -> takenValid=0 immediately; after release, flags=RESET_FLAGS and condReady=1.

Source files
------------

// File: rtl/flag_unit_if.sv
// Bundle for flag_unit: flag capture, condition request and branch-decision handshakes.
// The master modport drives requests and consumes decisions; the slave modport is the flag unit.
interface flag_unit_if;
  logic       setFlags;
  logic [3:0] aluFlags;
  logic       condValid;
  logic [3:0] cond;
  logic       condReady;
  logic       takenValid;
  logic       taken;
  logic       takenReady;
  logic [3:0] flags;

  modport master (
    output setFlags, aluFlags, condValid, cond, takenReady,
    input  condReady, takenValid, taken, flags
  );

  modport slave (
    input  setFlags, aluFlags, condValid, cond, takenReady,
    output condReady, takenValid, taken, flags
  );
endinterface

// File: rtl/flag_unit.sv
// ARM-style {N,Z,C,V} flag register with a one-entry condition-evaluation buffer.
// Optional macro FLAG_BYPASS_EN: evaluate same-cycle requests against aluFlags instead of stalling.
module flag_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter int         Delay       = 50
) (
  input logic        clk,
  input logic        reset,
  flag_unit_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bufStateT;

  // Delay is a back-annotation value for gate-level timing; RTL carries no delays.
  if (Delay < 0) begin : gDelayCheck
    $error("flag_unit: Delay must be non-negative");
  end

  bufStateT   state;
  bufStateT   stateNext;
  logic [3:0] flagsQ;
  logic       takenQ;
  logic       active;
  logic [3:0] evalFlags;
  logic       hazard;
  logic       condResult;
  logic       condReadyC;
  logic       accept;

  function automatic logic evalCond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'd0:    evalCond = z;
      4'd1:    evalCond = !z;
      4'd2:    evalCond = cy;
      4'd3:    evalCond = !cy;
      4'd4:    evalCond = n;
      4'd5:    evalCond = !n;
      4'd6:    evalCond = v;
      4'd7:    evalCond = !v;
      4'd8:    evalCond = cy & !z;
      4'd9:    evalCond = !cy | z;
      4'd10:   evalCond = (n == v);
      4'd11:   evalCond = (n != v);
      4'd12:   evalCond = !z & (n == v);
      4'd13:   evalCond = z | (n != v);
      default: evalCond = 1'b1;
    endcase
  endfunction

`ifdef FLAG_BYPASS_EN
  // Forward the incoming flags so a same-cycle request sees them without a stall.
  assign evalFlags = bus.setFlags ? bus.aluFlags : flagsQ;
  assign hazard    = 1'b0;
`else
  // The register is not updated yet, so hold the request off for one cycle.
  assign evalFlags = flagsQ;
  assign hazard    = bus.setFlags & bus.condValid;
`endif

  assign condResult = evalCond(bus.cond, evalFlags);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    condReadyC = 1'b0;
    stateNext  = state;
    if (active) begin
      condReadyC = ((state == EMPTY) ? 1'b1 : bus.takenReady) & !hazard;
    end
    accept = bus.condValid & condReadyC;
    case (state)
      EMPTY:   if (accept) stateNext = FULL;
      FULL:    if (!accept && bus.takenReady) stateNext = EMPTY;
      default: stateNext = EMPTY;
    endcase
  end

  // active stays low through reset so condReady is 0 until the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      flagsQ <= RESET_FLAGS;
      takenQ <= 1'b0;
      active <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state  <= stateNext;
      active <= 1'b1;
      if (bus.setFlags) flagsQ <= bus.aluFlags;
      if (accept) takenQ <= condResult;
    end
  end

  assign bus.condReady  = condReadyC;
  assign bus.takenValid = (state == FULL);
  assign bus.taken      = takenQ;
  assign bus.flags      = flagsQ;

endmodule
